// File: rtl/suma_pkg.sv
// Shared types for the operand-capture controller: FSM state encoding and
// bit positions inside the {N, Z, C, V} flag word.
package suma_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/suma_ctrl_if.sv
// Board/adder-facing bundle of the operand-capture controller.
// The slave side is the controller, the master side is whatever surrounds it.
interface suma_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] sw_i;
  logic         load_i;
  logic         clear_i;
  logic [N-1:0] a_o;
  logic [N-1:0] b_o;
  logic [N-1:0] sum_i;
  logic         cout_i;
  logic [N-1:0] result_o;
  logic [3:0]   flags_o;
  logic         valid_o;
  logic [1:0]   state_o;

  modport slave (
    input  sw_i, load_i, clear_i, sum_i, cout_i,
    output a_o, b_o, result_o, flags_o, valid_o, state_o
  );

  modport master (
    output sw_i, load_i, clear_i, sum_i, cout_i,
    input  a_o, b_o, result_o, flags_o, valid_o, state_o
  );
endinterface

// File: rtl/SumaNBit.sv
// N-bit ripple-carry adder that sits beside the controller in the lab top level.
module SumaNBit #(
  parameter int n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Sum,
  output logic         Cout
);

  logic [n:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_fa
      assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = carry[n];

endmodule

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a rising-edge
// detector: one single-cycle pulse per press, however long it is held.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/suma_ctrl.sv
// Captures operand A then B on successive load presses, feeds the external
// adder, and registers its sum plus {N, Z, C, V} one cycle after B lands.
module suma_ctrl
  import suma_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  suma_ctrl_if.slave  bus
);

  state_t       state_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic         valid_q;
  logic         load_pulse;

  sync_edge u_load_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (bus.load_i),
    .pulse_o (load_pulse)
  );

  // Clear is checked before the FSM so a press in the same cycle is dropped;
  // it deliberately leaves the load synchronizer alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else if (bus.clear_i) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (load_pulse) begin
            a_q     <= bus.sw_i;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (load_pulse) begin
            b_q     <= bus.sw_i;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q         <= bus.sum_i;
          flags_q[FLAG_N]  <= bus.sum_i[N-1];
          flags_q[FLAG_Z]  <= (bus.sum_i == '0);
          flags_q[FLAG_C]  <= bus.cout_i;
          // Signed overflow: like-signed operands giving a differently-signed sum.
          flags_q[FLAG_V]  <= (a_q[N-1] == b_q[N-1]) && (bus.sum_i[N-1] != a_q[N-1]);
          valid_q          <= 1'b1;
          state_q          <= S_DONE;
        end
        S_DONE: begin
          if (load_pulse) begin
            a_q     <= bus.sw_i;
            valid_q <= 1'b0;
            state_q <= S_B;
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign bus.a_o      = a_q;
  assign bus.b_o      = b_q;
  assign bus.result_o = result_q;
  assign bus.flags_o  = flags_q;
  assign bus.valid_o  = valid_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_suma_ctrl.sv
// Directed and random operand presses against the controller plus ripple adder,
// compared with an arithmetic model of what the board should display.
module tb_suma_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sum_w;
  logic       cout_w;
  logic [3:0] a_w;
  logic [3:0] b_w;

  int tests = 0;
  int fails = 0;

  int         m_state;
  logic [3:0] m_a, m_b, m_res, m_flags;
  logic       m_valid;

  suma_ctrl_if #(.N(4)) bus ();

  suma_ctrl #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign a_w = bus.a_o;
  assign b_w = bus.b_o;

  SumaNBit #(.n(4)) adder (
    .A    (a_w),
    .B    (b_w),
    .Sum  (sum_w),
    .Cout (cout_w)
  );

  assign bus.sum_i  = sum_w;
  assign bus.cout_i = cout_w;

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_flags = 0; m_valid = 0;
  endtask

  // Expected display after one accepted press with switches v.
  task automatic model_press(input logic [3:0] v);
    int u, sa, sb, ss;
    if (m_state == 1) begin
      m_b = v;
      u = int'(m_a) + int'(m_b);
      m_res = 4'(u % 16);
      sa = (m_a > 7) ? int'(m_a) - 16 : int'(m_a);
      sb = (m_b > 7) ? int'(m_b) - 16 : int'(m_b);
      ss = sa + sb;
      m_flags = {m_res >= 8, m_res == 0, u >= 16, (ss > 7) || (ss < -8)};
      m_valid = 1'b1;
      m_state = 3;
    end else begin
      m_a = v;
      m_valid = 1'b0;
      m_state = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  {6'd0, bus.state_o},  8'(m_state));
    chk({tag, ".a"},      {4'd0, bus.a_o},      {4'd0, m_a});
    chk({tag, ".b"},      {4'd0, bus.b_o},      {4'd0, m_b});
    chk({tag, ".result"}, {4'd0, bus.result_o}, {4'd0, m_res});
    chk({tag, ".flags"},  {4'd0, bus.flags_o},  {4'd0, m_flags});
    chk({tag, ".valid"},  {7'd0, bus.valid_o},  {7'd0, m_valid});
  endtask

  task automatic press(input logic [3:0] v, input string tag);
    bus.sw_i = v;
    bus.load_i = 1'b1;
    step(5);
    bus.load_i = 1'b0;
    step(5);
    model_press(v);
    check_all(tag);
    $display("[TB] %s press sw=%b state=%0d a=%b b=%b res=%b flags=%b valid=%0b",
             tag, v, bus.state_o, bus.a_o, bus.b_o, bus.result_o, bus.flags_o, bus.valid_o);
  endtask

  // B press with edge-accurate latency checks: capture at 3rd edge, result at 4th.
  task automatic press_b_timed(input logic [3:0] v, input string tag);
    bus.sw_i = v;
    bus.load_i = 1'b1;
    step(2);
    chk({tag, ".pre_state"}, {6'd0, bus.state_o}, 8'd1);
    step(1);
    chk({tag, ".exec_state"}, {6'd0, bus.state_o}, 8'd2);
    chk({tag, ".exec_b"}, {4'd0, bus.b_o}, {4'd0, v});
    chk({tag, ".exec_valid"}, {7'd0, bus.valid_o}, 8'd0);
    step(1);
    model_press(v);
    chk({tag, ".done_state"}, {6'd0, bus.state_o}, 8'd3);
    chk({tag, ".done_valid"}, {7'd0, bus.valid_o}, 8'd1);
    step(1);
    bus.load_i = 1'b0;
    step(5);
    check_all(tag);
    $display("[TB] %s B=%b res=%b flags=%b valid=%0b",
             tag, v, bus.result_o, bus.flags_o, bus.valid_o);
  endtask

  initial begin
    logic [3:0] ra, rb, v0;
    bus.sw_i = 4'd0;
    bus.load_i = 1'b0;
    bus.clear_i = 1'b0;
    model_clear();

    step(2);
    check_all("reset_hold");
    #2 rst_n = 1'b1;
    step(2);
    check_all("reset_release");

    // Directed vectors, plus the fixed expectations as literals.
    press(4'b0101, "v1A");
    press_b_timed(4'b1100, "v1B");
    chk("v1.result_lit", {4'd0, bus.result_o}, 8'b0001);
    chk("v1.flags_lit",  {4'd0, bus.flags_o},  8'b0010);
    press(4'b1111, "v2A");
    press_b_timed(4'b1111, "v2B");
    chk("v2.result_lit", {4'd0, bus.result_o}, 8'b1110);
    chk("v2.flags_lit",  {4'd0, bus.flags_o},  8'b1010);
    press(4'b0111, "v3A");
    press_b_timed(4'b0001, "v3B");
    chk("v3.result_lit", {4'd0, bus.result_o}, 8'b1000);
    chk("v3.flags_lit",  {4'd0, bus.flags_o},  8'b1001);
    press(4'b0000, "v4A");
    press_b_timed(4'b0000, "v4B");
    chk("v4.flags_lit",  {4'd0, bus.flags_o},  8'b0100);
    press(4'b1010, "done_press");
    chk("done_press.valid_lit", {7'd0, bus.valid_o}, 8'd0);
    chk("done_press.state_lit", {6'd0, bus.state_o}, 8'd1);

    // Random operand pairs.
    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if (m_state == 1) press(ra, "rndA_fromB");
      press(ra, "rndA");
      press_b_timed(rb, "rndB");
    end

    // Long hold with toggling switches: exactly one capture.
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
    model_clear();
    check_all("clear_before_hold");
    v0 = 4'($urandom_range(0, 15));
    bus.sw_i = v0;
    bus.load_i = 1'b1;
    step(3);
    model_press(v0);
    for (int c = 3; c < 50; c++) begin
      bus.sw_i = 4'($urandom_range(0, 15));
      step(1);
      if (c % 8 == 0) begin
        chk("hold.state", {6'd0, bus.state_o}, 8'd1);
        chk("hold.a", {4'd0, bus.a_o}, {4'd0, v0});
      end
    end
    bus.load_i = 1'b0;
    step(5);
    check_all("hold_end");
    $display("[TB] hold50 sw0=%b a=%b state=%0d", v0, bus.a_o, bus.state_o);

    // Clear coinciding with the load pulse while in S_B: clear wins, press lost.
    bus.sw_i = 4'b0110;
    bus.load_i = 1'b1;
    step(2);
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
    model_clear();
    check_all("clear_vs_press");
    step(3);
    bus.load_i = 1'b0;
    step(5);
    check_all("clear_press_lost");
    $display("[TB] clear_in_SB state=%0d a=%b", bus.state_o, bus.a_o);

    // Async reset while in S_EXEC.
    press(4'b0011, "rstA");
    bus.sw_i = 4'b0100;
    bus.load_i = 1'b1;
    step(3);
    chk("rst.exec_state", {6'd0, bus.state_o}, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all("rst_async");
    bus.load_i = 1'b0;
    step(3);
    #2 rst_n = 1'b1;
    step(6);
    check_all("rst_release");
    $display("[TB] reset_in_EXEC state=%0d valid=%0b", bus.state_o, bus.valid_o);

    press(4'b1001, "post_rstA");
    press_b_timed(4'b1001, "post_rstB");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
